// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-requester cache arbiter with round-robin grant and response timeout
module cache_arbiter #(
  parameter int d_width = 8,
  parameter int a_width = 8,
  parameter int timeout = 31
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req0,
  input  logic               req1,
  input  logic               rw0,
  input  logic               rw1,
  input  logic [a_width-1:0] addr0,
  input  logic [a_width-1:0] addr1,
  input  logic [d_width-1:0] wdata0,
  input  logic [d_width-1:0] wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [d_width-1:0] rdata,
  output logic               err,
  output logic [a_width-1:0] c_addr,
  output logic [d_width-1:0] c_wdata,
  output logic               c_rw,
  output logic               c_ce,
  input  logic [d_width-1:0] c_rdata,
  input  logic               c_odv
);

  localparam int c_width = $clog2(timeout + 1);
  localparam logic [c_width-1:0] count_max = c_width'(timeout);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic               owner;
  logic               last;
  logic [c_width-1:0] count;
  logic               pick;

  // On contention the requester that did not complete last wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
      pick = ~last;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      count   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      c_addr  <= '0;
      c_wdata <= '0;
      c_rw    <= 1'b0;
      c_ce    <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner  <= pick;
            gnt0   <= ~pick;
            gnt1   <= pick;
            c_rw   <= pick ? rw1 : rw0;
            c_addr <= pick ? addr1 : addr0;
            if (pick) begin
              c_wdata <= rw1 ? '0 : wdata1;
            end else begin
              c_wdata <= rw0 ? '0 : wdata0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          c_ce  <= 1'b1;
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (c_odv || count == count_max) begin
            c_ce  <= 1'b0;
            err   <= ~c_odv;
            // Writes and timeouts never return data.
            rdata <= (c_odv && c_rw) ? c_rdata : '0;
            done0 <= ~owner;
            done1 <= owner;
            last  <= owner;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          err   <= 1'b0;
          rdata <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, done0, done1, err, c_rw, c_ce;
  logic [7:0] rdata, c_addr, c_wdata;
  logic [7:0] c_rdata = '0;
  logic       c_odv = 1'b0;

  int checks = 0;
  int errors = 0;
  int ce_run = 0;
  int resp_lat = 1;
  logic [7:0] resp_data = 8'h00;
  logic odv_issue = 1'b0;

  cache_arbiter #(.d_width(8), .a_width(8), .timeout(31)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rw(c_rw), .c_ce(c_ce),
    .c_rdata(c_rdata), .c_odv(c_odv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the cache answers resp_lat cycles after c_ce first rises.
  task automatic step();
    @(posedge clk);
    #1;
    if (c_ce) ce_run++; else ce_run = 0;
    c_odv   = 1'b0;
    c_rdata = 8'hC3;
    if (odv_issue && (gnt0 || gnt1)) begin
      c_odv   = 1'b1;
      c_rdata = 8'h77;
    end else if (c_ce && ce_run == resp_lat + 1) begin
      c_odv   = 1'b1;
      c_rdata = resp_data;
    end
  endtask

  task automatic do_txn(input string tag, input logic who, input logic rw,
                        input logic [7:0] addr, input logic [7:0] wdata,
                        input int lat, input logic [7:0] resp,
                        input logic [7:0] exp_rdata, input logic exp_err, input int exp_ce);
    int n;
    int ce;
    int total;
    logic seen;
    resp_lat  = lat;
    resp_data = resp;
    if (who) begin
      req1 = 1'b1; rw1 = rw; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; rw0 = rw; addr0 = addr; wdata0 = wdata;
    end
    n = 0;
    do begin step(); n++; end while (!(gnt0 || gnt1) && n < 20);
    check({tag, "_gnt"}, 32'({gnt1, gnt0}), who ? 32'd2 : 32'd1);
    check({tag, "_gnt_lat"}, 32'(n), 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    total = n;
    ce = 0;
    seen = 1'b0;
    n = 0;
    do begin
      step(); n++; total++;
      if (c_ce) begin
        ce++;
        if (!seen) begin
          seen = 1'b1;
          check({tag, "_c_addr"}, 32'(c_addr), 32'(addr));
          check({tag, "_c_rw"}, 32'(c_rw), 32'(rw));
          check({tag, "_c_wdata"}, 32'(c_wdata), rw ? 32'd0 : 32'(wdata));
        end
      end
    end while (!(done0 || done1) && n < 100);
    check({tag, "_done"}, 32'({done1, done0}), who ? 32'd2 : 32'd1);
    check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_ce_cycles"}, 32'(ce), 32'(exp_ce));
    check({tag, "_latency"}, 32'(total), 32'(exp_ce + 2));
    check({tag, "_c_ce_off"}, 32'(c_ce), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'({done1, done0, err}), 32'd0);
  endtask

  initial begin
    int n;
    logic exp;
    int both;

    step(); step();
    check("rst_cmd", 32'({c_ce, c_rw, c_addr, c_wdata}), 32'd0);
    check("rst_flags", 32'({gnt0, gnt1, done0, done1, err}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    clr = 1'b1;
    step();
    check("idle_no_req", 32'({gnt0, gnt1, c_ce}), 32'd0);

    do_txn("rd0", 1'b0, 1'b1, 8'h3C, 8'h00, 1, 8'hA5, 8'hA5, 1'b0, 2);
    do_txn("wr1", 1'b1, 1'b0, 8'h10, 8'h5F, 1, 8'hEE, 8'h00, 1'b0, 2);
    do_txn("tmo", 1'b0, 1'b1, 8'h44, 8'h00, 1000, 8'h99, 8'h00, 1'b1, 32);
    do_txn("after_tmo", 1'b1, 1'b1, 8'h45, 8'h00, 3, 8'h81, 8'h81, 1'b0, 4);
    odv_issue = 1'b1;
    do_txn("odv_issue", 1'b1, 1'b1, 8'h46, 8'h00, 1000, 8'h55, 8'h00, 1'b1, 32);
    odv_issue = 1'b0;

    // Contention straight out of reset: 0 first, then strict alternation.
    clr = 1'b0;
    step();
    clr = 1'b1;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h01;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 8'h02;
    resp_lat = 1;
    resp_data = 8'h5A;
    exp = 1'b0;
    both = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin
        step(); n++;
        if (gnt0 && gnt1) both++;
      end while (!(gnt0 || gnt1) && n < 20);
      check("arb_gnt", 32'({gnt1, gnt0}), exp ? 32'd2 : 32'd1);
      check("arb_addr", 32'(c_addr), exp ? 32'h02 : 32'h01);
      if (k > 0) check("arb_regrant", 32'(n), 32'd2);
      n = 0;
      do begin
        step(); n++;
        if (done0 && done1) both++;
      end while (!(done0 || done1) && n < 50);
      check("arb_done", 32'({done1, done0}), exp ? 32'd2 : 32'd1);
      check("arb_rdata", 32'(rdata), 32'h5A);
      exp = ~exp;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("arb_exclusive", 32'(both), 32'd0);
    step(); step();

    // Reset while waiting on the cache; held request restarts afterwards.
    resp_lat = 1000;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h77;
    n = 0;
    do begin step(); n++; end while (!c_ce && n < 20);
    step(); step();
    check("rst_wait_ce", 32'(c_ce), 32'd1);
    clr = 1'b0;
    step();
    check("rst_wait_drop", 32'({c_ce, done0, done1, gnt0}), 32'd0);
    clr = 1'b1;
    resp_lat = 1;
    resp_data = 8'h3D;
    step();
    check("rst_regrant", 32'({gnt1, gnt0}), 32'd1);
    req0 = 1'b0;
    n = 0;
    do begin
      step(); n++;
    end while (!(done0 || done1) && n < 50);
    check("rst_after_done", 32'({done1, done0}), 32'd1);
    check("rst_after_rdata", 32'(rdata), 32'h3D);
    check("rst_after_lat", 32'(n), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
